// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and full/empty flags.
// Storage is a DEPTH-entry register array addressed by circular pointers.
// Optional build macro SYNC_FIFO_STATUS_EN adds count, overflow and underflow outputs.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
`ifdef SYNC_FIFO_STATUS_EN
  output logic                  empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic                  empty
`endif
);

  localparam logic [PTR_WIDTH:0]   FullCount = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   CountOne  = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] PtrOne    = PTR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  wr_acc, rd_acc;

  // Acceptance: a write into a full FIFO is allowed only when a read frees a slot
  // on the same edge; a read needs stored data (no fall-through of same-cycle writes).
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
  end

  // Occupancy next state; simultaneous accepted read and write cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // Pointers, occupancy and registered read data; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      count_q <= count_d;
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (rd_acc) begin
        // On a full write+read, wr_ptr == rd_ptr and this still returns the oldest word.
        data_out_q <= mem[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + PtrOne;
      end
    end
  end

  // Flags decoded from the registered count, so they move on the same edge as it.
  always_comb begin
    full     = (count_q == FullCount);
    empty    = (count_q == '0);
    data_out = data_out_q;
  end

`ifdef SYNC_FIFO_STATUS_EN
  logic overflow_q, underflow_q;

  // One-cycle pulses for dropped writes and ignored reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= wr_en && !wr_acc;
      underflow_q <= rd_en && empty;
    end
  end

  // Status outputs.
  always_comb begin
    count     = count_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo.
// Status-port checks are compiled in when SYNC_FIFO_STATUS_EN is defined.
module tb_sync_fifo;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        full;
  logic        empty;
`ifdef SYNC_FIFO_STATUS_EN
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;
`endif

  int checks = 0;
  int errors = 0;

  sync_fifo #(
    .DATA_WIDTH(16),
    .DEPTH     (16),
    .PTR_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
`ifdef SYNC_FIFO_STATUS_EN
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
`else
    .empty    (empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    #2;
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_dout", 32'(data_out), 32'd0);
    tick();
    rst = 1'b0;

    // Basic ordering
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; data_in = 16'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    check("basic_not_empty", 32'(empty), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      rd_en = 1'b1;
      tick();
      check("basic_read", 32'(data_out), 32'(i));
    end
    rd_en = 1'b0;
    check("basic_empty_after", 32'(empty), 32'd1);

    // Fill and overflow
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; data_in = 16'(i);
      tick();
      if (i == 15) check("fill_not_full_15", 32'(full), 32'd0);
    end
    check("fill_full_16", 32'(full), 32'd1);
    data_in = 16'hFFFF;
    tick();
    wr_en = 1'b0;
    check("overflow_full_kept", 32'(full), 32'd1);
`ifdef SYNC_FIFO_STATUS_EN
    check("overflow_pulse", 32'(overflow), 32'd1);
    check("overflow_count", 32'(count), 32'd16);
    tick();
    check("overflow_pulse_end", 32'(overflow), 32'd0);
`endif
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      tick();
      check("fill_read", 32'(data_out), 32'(i));
      if (i == 1) check("fill_not_full_after_read", 32'(full), 32'd0);
    end
    rd_en = 1'b0;
    check("fill_empty_after", 32'(empty), 32'd1);

    // Underflow after reset
    #2;
    rst = 1'b1;
    #1;
    check("uf_reset_dout", 32'(data_out), 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      check("uf_dout_hold", 32'(data_out), 32'd0);
      check("uf_empty", 32'(empty), 32'd1);
`ifdef SYNC_FIFO_STATUS_EN
      check("uf_pulse", 32'(underflow), 32'd1);
`endif
    end
    rd_en = 1'b0;

    // Simultaneous read/write with one entry stored
    wr_en = 1'b1; data_in = 16'h000A;
    tick();
    rd_en = 1'b1; data_in = 16'h000B;
    tick();
    check("sim_dout_a", 32'(data_out), 32'h000A);
    check("sim_not_empty", 32'(empty), 32'd0);
`ifdef SYNC_FIFO_STATUS_EN
    check("sim_count", 32'(count), 32'd1);
`endif
    wr_en = 1'b0;
    tick();
    check("sim_dout_b", 32'(data_out), 32'h000B);
    check("sim_empty", 32'(empty), 32'd1);

    // Simultaneous on empty: write only, no fall-through
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h000C;
    tick();
    check("sim_empty_no_fallthrough", 32'(data_out), 32'h000B);
    check("sim_empty_written", 32'(empty), 32'd0);
    wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
    check("sim_empty_read_c", 32'(data_out), 32'h000C);
    check("sim_empty_drained", 32'(empty), 32'd1);

    // Simultaneous on full
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; data_in = 16'(32'h100 + i);
      tick();
    end
    rd_en = 1'b1; data_in = 16'h0200;
    tick();
    wr_en = 1'b0;
    check("simfull_full_kept", 32'(full), 32'd1);
    check("simfull_oldest", 32'(data_out), 32'h0100);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("simfull_drain", 32'(data_out), (i == 16) ? 32'h0200 : 32'h100 + i);
    end
    rd_en = 1'b0;
    check("simfull_empty", 32'(empty), 32'd1);

    // Wrap-around rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        wr_en = 1'b1; data_in = 16'(32'h300 + r * 10 + i);
        tick();
      end
      wr_en = 1'b0;
      check("wrap_not_empty", 32'(empty), 32'd0);
      check("wrap_not_full", 32'(full), 32'd0);
      for (int i = 0; i < 10; i++) begin
        rd_en = 1'b1;
        tick();
        check("wrap_read", 32'(data_out), 32'h300 + r * 10 + i);
      end
      rd_en = 1'b0;
      check("wrap_empty", 32'(empty), 32'd1);
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; data_in = 16'(32'h400 + i);
      tick();
    end
    wr_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_dout", 32'(data_out), 32'd0);
    #2;
    rst = 1'b0;
    wr_en = 1'b1; data_in = 16'h1234;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("midrst_read", 32'(data_out), 32'h1234);
    check("midrst_empty_after", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
